// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RV M-extension unit; radix-2 shift-add multiply, restoring divide.
// Optional build macro RV_MULDIV_EARLY_OUT_EN lets trivial mul/div cases bypass the iteration.
module rv_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] dvsr;
    logic            neg_q;

    logic            load_op;
    logic            step;
    logic            load_res;
    logic [XLEN-1:0] res_next;

    // Launch decode: signedness per funct3, operand magnitudes, final sign
    logic            is_div_in;
    logic            sgn_a_in;
    logic            sgn_b_in;
    logic            neg_a;
    logic            neg_b;
    logic            b_zero;
    logic            neg_in;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign is_div_in = op[2];
    assign sgn_a_in  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign sgn_b_in  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a     = sgn_a_in && a[XLEN-1];
    assign neg_b     = sgn_b_in && b[XLEN-1];
    assign mag_a     = neg_a ? -a : a;
    assign mag_b     = neg_b ? -b : b;
    assign b_zero    = (b == '0);

    // Remainder follows the dividend; a zero divisor keeps the all-ones quotient unsigned
    always_comb begin
        if (is_div_in) begin
            neg_in = op[1] ? neg_a : ((neg_a ^ neg_b) && !b_zero);
        end else begin
            neg_in = neg_a ^ neg_b;
        end
    end

`ifdef RV_MULDIV_EARLY_OUT_EN
    logic            a_zero;
    logic            div_ovf;
    logic            early;
    logic [XLEN-1:0] early_res;
    logic [XLEN-1:0] min_neg;

    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
    assign a_zero  = (a == '0);
    assign div_ovf = is_div_in && !op[0] && (a == min_neg) && (b == '1);
    assign early   = is_div_in ? (b_zero || div_ovf) : (a_zero || b_zero);

    always_comb begin
        if (!is_div_in) begin
            early_res = '0;
        end else if (b_zero) begin
            early_res = op[1] ? a : '1;
        end else begin
            early_res = op[1] ? '0 : a;
        end
    end
`endif

    // One iteration of the shared datapath; hi/lo form the product or remainder/quotient
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shr;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
        div_shr = {hi, lo[XLEN-1]};
        div_sub = div_shr[XLEN-1:0] - dvsr;
        div_ge  = (div_shr >= {1'b0, dvsr});
        if (op_q[2]) begin
            hi_n = div_ge ? div_sub : div_shr[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign fix-up; upper half of a negated product carries in only when the low half is zero
    logic [XLEN-1:0] div_val;
    logic [XLEN-1:0] res_calc;

    always_comb begin
        div_val = op_q[1] ? hi_n : lo_n;
        if (op_q[2]) begin
            res_calc = neg_q ? -div_val : div_val;
        end else if (op_q[1:0] == 2'b00) begin
            res_calc = lo_n;
        end else begin
            res_calc = neg_q ? (~hi_n + XLEN'(lo_n == '0)) : hi_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; flush overrides everything
    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        step       = 1'b0;
        load_res   = 1'b0;
        res_next   = res_calc;
        case (state)
            IDLE: begin
                if (start) begin
                    load_op    = 1'b1;
                    state_next = CALC;
`ifdef RV_MULDIV_EARLY_OUT_EN
                    if (early) begin
                        state_next = FIN;
                        load_res   = 1'b1;
                        res_next   = early_res;
                    end
`endif
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == CW'(1)) begin
                    state_next = FIN;
                    load_res   = 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
            load_op    = 1'b0;
            step       = 1'b0;
            load_res   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
        end else if (load_op) begin
            count <= CW'(XLEN);
            op_q  <= op;
            hi    <= '0;
            lo    <= is_div_in ? mag_a : mag_b;
            dvsr  <= is_div_in ? mag_b : mag_a;
            neg_q <= neg_in;
        end else if (step) begin
            count <= count - CW'(1);
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= load_res;
            if (load_res) begin
                result <= res_next;
            end
        end
    end

endmodule
